d_port_serializer: RTL and testbench

//   Downstream consumer of the 3-way arbitrated D port. Buffers WIDTH-bit arbitrated

---
 rtl/d_port_serializer_pkg.sv | 29 ++
 rtl/d_port_serializer_if.sv | 64 ++++++
 rtl/d_sink_fifo.sv | 81 ++++++++
 rtl/d_port_serializer.sv | 159 +++++++++++++++
 tb/tb_d_port_serializer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/d_port_serializer_pkg.sv
// ----------------------------------------------------------------------------
// d_port_serializer_pkg
//   Shared types and width helpers for the D-port serializer slice.
//   - serState_e : serializer FSM states (IDLE=0, SHIFT=1)
//   - levelWidth : bits needed to hold an occupancy of 0..depth inclusive
//   - ptrWidth   : bits needed to address depth entries (minimum 1)
//   - cntWidth   : bits needed for a beat counter 0..ratio-1 (minimum 1)
// ----------------------------------------------------------------------------
package d_port_serializer_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } serState_e;

    // Occupancy has depth+1 states so that full and empty stay distinct.
    function automatic int unsigned levelWidth(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptrWidth(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cntWidth(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/d_port_serializer_if.sv
// ----------------------------------------------------------------------------
// d_port_serializer_if
//   Bundles the arbitrated D-port input, the grant back to the arbiter and the
//   narrow valid/ready beat stream with its status outputs.
//   Signals:
//     i_DataValid  arbitrated word valid (no back-pressure)
//     i_Data       arbitrated word, WIDTH bits
//     o_DataGrant  registered grant/enable back to the arbiter
//     o_Valid      output beat valid
//     o_Data       output beat, OUT_WIDTH bits, LSB slice of a word first
//     o_Last       high on the final beat of each word
//     i_Ready      downstream accepts the beat when o_Valid & i_Ready
//     o_Level      FIFO occupancy in words
//     o_Overflow   sticky: a word arrived while the FIFO was full
//   Modports:
//     master : environment side (drives inputs, observes outputs)
//     slave  : serializer side
// ----------------------------------------------------------------------------
interface d_port_serializer_if
    import d_port_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned RATIO      = 4,
    parameter int unsigned FIFO_DEPTH = 8
);

    localparam int unsigned OUT_WIDTH   = WIDTH / RATIO;
    localparam int unsigned LEVEL_WIDTH = levelWidth(FIFO_DEPTH);

    logic                   i_DataValid;
    logic [WIDTH-1:0]       i_Data;
    logic                   o_DataGrant;
    logic                   o_Valid;
    logic [OUT_WIDTH-1:0]   o_Data;
    logic                   o_Last;
    logic                   i_Ready;
    logic [LEVEL_WIDTH-1:0] o_Level;
    logic                   o_Overflow;

    modport master (
        output i_DataValid,
        output i_Data,
        output i_Ready,
        input  o_DataGrant,
        input  o_Valid,
        input  o_Data,
        input  o_Last,
        input  o_Level,
        input  o_Overflow
    );

    modport slave (
        input  i_DataValid,
        input  i_Data,
        input  i_Ready,
        output o_DataGrant,
        output o_Valid,
        output o_Data,
        output o_Last,
        output o_Level,
        output o_Overflow
    );

endinterface

// File: rtl/d_sink_fifo.sv
// ----------------------------------------------------------------------------
// d_sink_fifo
//   Synchronous FIFO buffering arbitrated words. Read data is taken straight
//   from the storage array at the read pointer (no output register stage), so
//   popData is valid in the same cycle that empty is low.
//   Ports:
//     CLK       clock, rising edge
//     Reset     asynchronous, active-high; empties the FIFO
//     push      write pushData this cycle (ignored when full unless popping)
//     pushData  word to store
//     pop       consume the head word this cycle (ignored when empty)
//     popData   head word
//     full      level == DEPTH
//     empty     level == 0
//     level     occupancy in words, 0..DEPTH
// ----------------------------------------------------------------------------
module d_sink_fifo
    import d_port_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             pushData,
    input  logic                         pop,
    output logic [WIDTH-1:0]             popData,
    output logic                         full,
    output logic                         empty,
    output logic [levelWidth(DEPTH)-1:0] level
);

    localparam int unsigned PTR_WIDTH   = ptrWidth(DEPTH);
    localparam int unsigned LEVEL_WIDTH = levelWidth(DEPTH);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [PTR_WIDTH-1:0]   wrPtrQ;
    logic [PTR_WIDTH-1:0]   rdPtrQ;
    logic [LEVEL_WIDTH-1:0] levelQ;
    logic                   doPush;
    logic                   doPop;

    assign empty   = (levelQ == '0);
    assign full    = (levelQ == LEVEL_WIDTH'(DEPTH));
    assign level   = levelQ;
    assign popData = mem[rdPtrQ];

    // A full FIFO may still accept a word when the head leaves in the same cycle.
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);

    // Pointers are power-of-two wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            levelQ <= '0;
        end else begin
            if (doPush) begin
                wrPtrQ <= wrPtrQ + PTR_WIDTH'(1);
            end
            if (doPop) begin
                rdPtrQ <= rdPtrQ + PTR_WIDTH'(1);
            end
            if (doPush && !doPop) begin
                levelQ <= levelQ + LEVEL_WIDTH'(1);
            end else if (doPop && !doPush) begin
                levelQ <= levelQ - LEVEL_WIDTH'(1);
            end
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (doPush) begin
            mem[wrPtrQ] <= pushData;
        end
    end

endmodule

// File: rtl/d_port_serializer.sv
// ----------------------------------------------------------------------------
// d_port_serializer
//   Downstream consumer of the 3-way arbitrated D port. Arbitrated words are
//   buffered in d_sink_fifo and emitted as RATIO narrower beats, LSB slice
//   first, on a valid/ready stream with a last-beat marker. The grant back to
//   the arbiter is derived from FIFO headroom, keeping GRANT_MARGIN slots free
//   for words already in flight when the grant drops.
//   Ports:
//     CLK    clock, rising edge
//     Reset  asynchronous, active-high
//     bus    d_port_serializer_if.slave (word input, grant, beat stream, status)
// ----------------------------------------------------------------------------
module d_port_serializer
    import d_port_serializer_pkg::*;
#(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned RATIO        = 4,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned GRANT_MARGIN = 2
) (
    input  logic                    CLK,
    input  logic                    Reset,
    d_port_serializer_if.slave      bus
);

    localparam int unsigned OUT_WIDTH   = WIDTH / RATIO;
    localparam int unsigned LEVEL_WIDTH = levelWidth(FIFO_DEPTH);
    localparam int unsigned CNT_WIDTH   = cntWidth(RATIO);

    localparam logic [LEVEL_WIDTH-1:0] DepthLevel  = LEVEL_WIDTH'(FIFO_DEPTH);
    localparam logic [LEVEL_WIDTH-1:0] MarginLevel = LEVEL_WIDTH'(GRANT_MARGIN);
    localparam logic [CNT_WIDTH-1:0]   LastCnt     = CNT_WIDTH'(RATIO - 1);

    // FIFO interface
    logic                   push;
    logic                   pop;
    logic [WIDTH-1:0]       fifoData;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic [LEVEL_WIDTH-1:0] fifoLevel;
    logic [LEVEL_WIDTH-1:0] levelNext;

    // Serializer state
    serState_e              stateQ, stateD;
    logic [WIDTH-1:0]       shiftQ, shiftD;
    logic [CNT_WIDTH-1:0]   cntQ, cntD;
    logic                   lastBeat;
    logic                   beatValid;

    // Grant and overflow
    logic                   grantQ, grantD;
    logic                   overflowQ, overflowD;

    d_sink_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .Reset    (Reset),
        .push     (push),
        .pushData (bus.i_Data),
        .pop      (pop),
        .popData  (fifoData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .level    (fifoLevel)
    );

    // ------------------------------------------------------------------
    // Input side: no back-pressure, a word is either stored or dropped.
    // ------------------------------------------------------------------
    assign push      = bus.i_DataValid & (~fifoFull | pop);
    assign overflowD = overflowQ | (bus.i_DataValid & fifoFull & ~pop);

    always_comb begin
        levelNext = fifoLevel;
        if (push && !pop) begin
            levelNext = fifoLevel + LEVEL_WIDTH'(1);
        end else if (pop && !push) begin
            levelNext = fifoLevel - LEVEL_WIDTH'(1);
        end
    end

    // Grant looks at next-cycle occupancy so it reacts in the same edge the
    // level changes; levelNext never exceeds FIFO_DEPTH, so no underflow.
    assign grantD = (DepthLevel - levelNext) > MarginLevel;

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    assign beatValid = (stateQ == StShift);
    assign lastBeat  = (cntQ == LastCnt);

    always_comb begin
        stateD = stateQ;
        shiftD = shiftQ;
        cntD   = cntQ;
        pop    = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (!fifoEmpty) begin
                    pop    = 1'b1;
                    shiftD = fifoData;
                    cntD   = '0;
                    stateD = StShift;
                end
            end

            StShift: begin
                if (bus.i_Ready) begin
                    if (!lastBeat) begin
                        shiftD = shiftQ >> OUT_WIDTH;
                        cntD   = cntQ + CNT_WIDTH'(1);
                    end else if (!fifoEmpty) begin
                        // Reload on the final handshake so words stream without a bubble.
                        pop    = 1'b1;
                        shiftD = fifoData;
                        cntD   = '0;
                    end else begin
                        stateD = StIdle;
                    end
                end
            end

            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stateQ    <= StIdle;
            shiftQ    <= '0;
            cntQ      <= '0;
            grantQ    <= 1'b0;
            overflowQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            shiftQ    <= shiftD;
            cntQ      <= cntD;
            grantQ    <= grantD;
            overflowQ <= overflowD;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Data is forced to zero while idle so a stale slice never shows.
    assign bus.o_Valid     = beatValid;
    assign bus.o_Data      = beatValid ? shiftQ[OUT_WIDTH-1:0] : '0;
    assign bus.o_Last      = beatValid & lastBeat;
    assign bus.o_Level     = fifoLevel;
    assign bus.o_Overflow  = overflowQ;
    assign bus.o_DataGrant = grantQ;

endmodule

// File: tb/tb_d_port_serializer.sv
// ----------------------------------------------------------------------------
// tb_d_port_serializer
//   Directed and randomized stimulus for d_port_serializer. A queue-based
//   reference (words waiting, beats of the word being emitted) predicts every
//   output each cycle. Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_d_port_serializer;

    localparam int unsigned WIDTH        = 64;
    localparam int unsigned RATIO        = 4;
    localparam int unsigned FIFO_DEPTH   = 8;
    localparam int unsigned GRANT_MARGIN = 2;
    localparam int unsigned OUT_WIDTH    = WIDTH / RATIO;

    logic CLK = 1'b0;
    logic Reset;

    always #5 CLK = ~CLK;

    d_port_serializer_if #(
        .WIDTH      (WIDTH),
        .RATIO      (RATIO),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) bus ();

    d_port_serializer #(
        .WIDTH        (WIDTH),
        .RATIO        (RATIO),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .GRANT_MARGIN (GRANT_MARGIN)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    int nAsserts = 0;
    int nFails   = 0;

    // Reference state
    logic [WIDTH-1:0]     fifoM  [$];
    logic [OUT_WIDTH-1:0] beatsM [$];
    logic                 grantM;
    logic                 ovfM;

    // Measurements taken from the DUT
    int peakLevel;
    int beatCount;
    int nValid;

    logic [OUT_WIDTH-1:0] t1Beats [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        fifoM.delete();
        beatsM.delete();
        grantM = 1'b0;
        ovfM   = 1'b0;
    endtask

    task automatic checkOutputs();
        bit busy;
        busy = (beatsM.size() != 0);
        chk("o_Valid", 64'(bus.o_Valid), 64'(busy));
        chk("o_Data", 64'(bus.o_Data), busy ? 64'(beatsM[0]) : 64'd0);
        chk("o_Last", 64'(bus.o_Last), 64'(busy && beatsM.size() == 1));
        chk("o_Level", 64'(bus.o_Level), 64'(fifoM.size()));
        chk("o_DataGrant", 64'(bus.o_DataGrant), 64'(grantM));
        chk("o_Overflow", 64'(bus.o_Overflow), 64'(ovfM));
    endtask

    // One clock: check the present outputs, apply inputs, advance the reference.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r);
        bit busy, doPop, doPush;
        logic [WIDTH-1:0] w;
        checkOutputs();
        if (int'(bus.o_Level) > peakLevel) peakLevel = int'(bus.o_Level);
        if (bus.o_Valid && r) beatCount++;
        bus.i_DataValid = v;
        bus.i_Data      = d;
        bus.i_Ready     = r;
        busy   = (beatsM.size() != 0);
        doPop  = (fifoM.size() != 0) && (!busy || (r && beatsM.size() == 1));
        doPush = v && ((fifoM.size() < int'(FIFO_DEPTH)) || doPop);
        if (v && !doPush) ovfM = 1'b1;
        if (busy && r) beatsM.delete(0);
        if (doPop) begin
            w = fifoM.pop_front();
            for (int i = 0; i < int'(RATIO); i++) beatsM.push_back(w[i*OUT_WIDTH +: OUT_WIDTH]);
        end
        if (doPush) fifoM.push_back(d);
        grantM = (int'(FIFO_DEPTH) - fifoM.size()) > int'(GRANT_MARGIN);
        @(negedge CLK);
    endtask

    task automatic drain(input int maxCycles);
        int n;
        n = 0;
        while ((fifoM.size() != 0 || beatsM.size() != 0) && n < maxCycles) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        chk("drain o_Valid", 64'(bus.o_Valid), 64'd0);
        chk("drain o_Level", 64'(bus.o_Level), 64'd0);
    endtask

    function automatic logic [WIDTH-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        t1Beats = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        Reset           = 1'b1;
        bus.i_DataValid = 1'b0;
        bus.i_Data      = '0;
        bus.i_Ready     = 1'b0;
        modelReset();
        peakLevel = 0;
        beatCount = 0;
        repeat (2) @(negedge CLK);

        // Reset state
        chk("rst o_Valid", 64'(bus.o_Valid), 64'd0);
        chk("rst o_Data", 64'(bus.o_Data), 64'd0);
        chk("rst o_Last", 64'(bus.o_Last), 64'd0);
        chk("rst o_Level", 64'(bus.o_Level), 64'd0);
        chk("rst o_Overflow", 64'(bus.o_Overflow), 64'd0);
        chk("rst o_DataGrant", 64'(bus.o_DataGrant), 64'd0);
        Reset = 1'b0;
        cycle(1'b0, '0, 1'b1);
        chk("grant after release", 64'(bus.o_DataGrant), 64'd1);

        // 1: single word, ready high, two-edge latency
        cycle(1'b1, 64'h4444_3333_2222_1111, 1'b1);
        chk("t1 level", 64'(bus.o_Level), 64'd1);
        chk("t1 not yet valid", 64'(bus.o_Valid), 64'd0);
        cycle(1'b0, '0, 1'b1);
        for (int b = 0; b < 4; b++) begin
            chk("t1 beat valid", 64'(bus.o_Valid), 64'd1);
            chk("t1 beat data", 64'(bus.o_Data), 64'(t1Beats[b]));
            chk("t1 beat last", 64'(bus.o_Last), 64'(b == 3));
            cycle(1'b0, '0, 1'b1);
        end
        chk("t1 done", 64'(bus.o_Valid), 64'd0);

        // 2: four back-to-back words
        peakLevel = 0;
        nValid    = 0;
        for (int i = 0; i < 24; i++) begin
            if (bus.o_Valid) nValid++;
            cycle(i < 4, rnd64(), 1'b1);
        end
        chk("t2 valid beats", 64'(nValid), 64'd16);
        chk("t2 peak level", 64'(peakLevel), 64'd3);

        // 3: stalled consumer fills the FIFO; one word sits in the shift register
        for (int i = 0; i < 9; i++) cycle(1'b1, rnd64(), 1'b0);
        chk("t3 level full", 64'(bus.o_Level), 64'd8);
        chk("t3 grant low", 64'(bus.o_DataGrant), 64'd0);
        chk("t3 no overflow yet", 64'(bus.o_Overflow), 64'd0);
        cycle(1'b1, rnd64(), 1'b0);
        chk("t3 overflow", 64'(bus.o_Overflow), 64'd1);
        chk("t3 level held", 64'(bus.o_Level), 64'd8);
        beatCount = 0;
        drain(80);
        chk("t3 beats out", 64'(beatCount), 64'd36);

        // 6: reset in the middle of a word
        cycle(1'b1, rnd64(), 1'b1);
        n = 0;
        while (beatsM.size() != 2 && n < 10) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        chk("t6 mid-word valid", 64'(bus.o_Valid), 64'd1);
        chk("t6 overflow before", 64'(bus.o_Overflow), 64'd1);
        #2 Reset = 1'b1;
        #1;
        chk("t6 async o_Valid", 64'(bus.o_Valid), 64'd0);
        chk("t6 async o_Data", 64'(bus.o_Data), 64'd0);
        chk("t6 async o_Last", 64'(bus.o_Last), 64'd0);
        chk("t6 async o_Level", 64'(bus.o_Level), 64'd0);
        chk("t6 async o_Overflow", 64'(bus.o_Overflow), 64'd0);
        chk("t6 async o_DataGrant", 64'(bus.o_DataGrant), 64'd0);
        modelReset();
        @(negedge CLK);
        Reset = 1'b0;
        chk("t6 grant first cycle", 64'(bus.o_DataGrant), 64'd0);
        cycle(1'b0, '0, 1'b0);
        chk("t6 grant second cycle", 64'(bus.o_DataGrant), 64'd1);
        chk("t6 overflow cleared", 64'(bus.o_Overflow), 64'd0);

        // 4: ready toggling every cycle
        beatCount = 0;
        for (int i = 0; i < 40; i++) cycle(i < 3, rnd64(), (i % 2) == 1);
        drain(20);
        chk("t4 beats out", 64'(beatCount), 64'd12);

        // 5: full FIFO, last beat accepted while a new word arrives
        for (int i = 0; i < 9; i++) cycle(1'b1, rnd64(), 1'b0);
        chk("t5 level full", 64'(bus.o_Level), 64'd8);
        repeat (3) cycle(1'b0, '0, 1'b1);
        chk("t5 last showing", 64'(bus.o_Last), 64'd1);
        cycle(1'b1, rnd64(), 1'b1);
        chk("t5 level stays", 64'(bus.o_Level), 64'd8);
        chk("t5 no overflow", 64'(bus.o_Overflow), 64'd0);
        drain(60);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 2) == 0, rnd64(), $urandom_range(0, 3) != 0);
        end
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
